// File: rtl/core_types_pkg.sv
// Shared core types: physical register tag width (64 physical registers).
package core_types_pkg;

  typedef logic [5:0] phys_reg_tag_t;

endpackage

// File: rtl/phys_reg_ready_table.sv
// phys_reg_ready_table
//   64-entry ready-bit scoreboard indexed by physical register tag.
//   Dispatch clears the destination entry, the two complete buses set entries,
//   and two combinational source ports read the table.
//   Entry 0 is hard-wired ready. A same-cycle clear beats a same-cycle set.
//   Optional feature macro: PRRT_COMPLETE_BYPASS_EN
//     defined   - a source read whose tag matches a valid complete bus in the
//                 same cycle returns 1.
//     undefined - source reads return registered table state only.
module phys_reg_ready_table
  import core_types_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  output logic          DUT_error,
  input  phys_reg_tag_t dispatch_source_0_phys_reg_tag,
  output logic          dispatch_source_0_ready,
  input  phys_reg_tag_t dispatch_source_1_phys_reg_tag,
  output logic          dispatch_source_1_ready,
  input  logic          dispatch_dest_write,
  input  phys_reg_tag_t dispatch_dest_phys_reg_tag,
  input  logic          complete_bus_0_valid,
  input  phys_reg_tag_t complete_bus_0_dest_phys_reg_tag,
  input  logic          complete_bus_1_valid,
  input  phys_reg_tag_t complete_bus_1_dest_phys_reg_tag
);

  logic [63:0] r_ready;
  logic [63:0] w_ready;
  logic [63:0] w_ready_next;
  logic        w_src0_bypass;
  logic        w_src1_bypass;
  logic        w_err_dup;
  logic        w_err_set0;
  logic        w_err_set1;

  // Entry 0 always reads ready regardless of stored state.
  assign w_ready = {r_ready[63:1], 1'b1};

  // Next table state: complete sets first, dispatch clear overrides, entry 0 pinned.
  always_comb begin
    w_ready_next = r_ready;
    if (complete_bus_0_valid) begin
      w_ready_next[complete_bus_0_dest_phys_reg_tag] = 1'b1;
    end
    if (complete_bus_1_valid) begin
      w_ready_next[complete_bus_1_dest_phys_reg_tag] = 1'b1;
    end
    if (dispatch_dest_write) begin
      w_ready_next[dispatch_dest_phys_reg_tag] = 1'b0;
    end
    w_ready_next[0] = 1'b1;
  end

  // Table register; asynchronous reset marks every register ready.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ready <= '1;
    end else begin
      r_ready <= w_ready_next;
    end
  end

`ifdef PRRT_COMPLETE_BYPASS_EN
  // Forward same-cycle completes to the source read ports.
  always_comb begin
    w_src0_bypass =
      (complete_bus_0_valid && (complete_bus_0_dest_phys_reg_tag == dispatch_source_0_phys_reg_tag)) ||
      (complete_bus_1_valid && (complete_bus_1_dest_phys_reg_tag == dispatch_source_0_phys_reg_tag));
    w_src1_bypass =
      (complete_bus_0_valid && (complete_bus_0_dest_phys_reg_tag == dispatch_source_1_phys_reg_tag)) ||
      (complete_bus_1_valid && (complete_bus_1_dest_phys_reg_tag == dispatch_source_1_phys_reg_tag));
  end
`else
  // No forwarding: reads see registered state only.
  always_comb begin
    w_src0_bypass = 1'b0;
    w_src1_bypass = 1'b0;
  end
`endif

  // Source reads use pre-update state, so a same-cycle clear is not visible.
  always_comb begin
    dispatch_source_0_ready = w_ready[dispatch_source_0_phys_reg_tag] | w_src0_bypass;
    dispatch_source_1_ready = w_ready[dispatch_source_1_phys_reg_tag] | w_src1_bypass;
  end

  // Protocol checks: duplicate complete tags, or completing an already-ready entry.
  // Suppressed during reset because the table then reads all-ready.
  always_comb begin
    w_err_dup  = complete_bus_0_valid && complete_bus_1_valid &&
                 (complete_bus_0_dest_phys_reg_tag == complete_bus_1_dest_phys_reg_tag) &&
                 (complete_bus_0_dest_phys_reg_tag != '0);
    w_err_set0 = complete_bus_0_valid && (complete_bus_0_dest_phys_reg_tag != '0) &&
                 w_ready[complete_bus_0_dest_phys_reg_tag];
    w_err_set1 = complete_bus_1_valid && (complete_bus_1_dest_phys_reg_tag != '0) &&
                 w_ready[complete_bus_1_dest_phys_reg_tag];
    DUT_error  = nRST && (w_err_dup || w_err_set0 || w_err_set1);
  end

endmodule

// File: tb/tb_phys_reg_ready_table.sv
// Scoreboard bench for phys_reg_ready_table: the driver pushes expected read
// results from a behavioural model, the monitor pops and compares on each
// falling clock edge.
module tb_phys_reg_ready_table;
  import core_types_pkg::*;

  logic          CLK;
  logic          nRST;
  logic          DUT_error;
  phys_reg_tag_t src0_tag;
  logic          src0_ready;
  phys_reg_tag_t src1_tag;
  logic          src1_ready;
  logic          dest_write;
  phys_reg_tag_t dest_tag;
  logic          cb0_valid;
  phys_reg_tag_t cb0_tag;
  logic          cb1_valid;
  phys_reg_tag_t cb1_tag;

  phys_reg_ready_table u_dut (
    .CLK                              (CLK),
    .nRST                             (nRST),
    .DUT_error                        (DUT_error),
    .dispatch_source_0_phys_reg_tag   (src0_tag),
    .dispatch_source_0_ready          (src0_ready),
    .dispatch_source_1_phys_reg_tag   (src1_tag),
    .dispatch_source_1_ready          (src1_ready),
    .dispatch_dest_write              (dest_write),
    .dispatch_dest_phys_reg_tag       (dest_tag),
    .complete_bus_0_valid             (cb0_valid),
    .complete_bus_0_dest_phys_reg_tag (cb0_tag),
    .complete_bus_1_valid             (cb1_valid),
    .complete_bus_1_dest_phys_reg_tag (cb1_tag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string name;
    logic  s0;
    logic  s1;
    logic  err;
  } exp_t;

  exp_t q[$];
  bit   model [64];
  int   n_cmp  = 0;
  int   n_fail = 0;

`ifdef PRRT_COMPLETE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic bit rd(input int t, input bit v0, input int c0, input bit v1, input int c1);
    bit r;
    r = (t == 0) ? 1'b1 : model[t];
    if (BYPASS && ((v0 && c0 == t) || (v1 && c1 == t))) r = 1'b1;
    return r;
  endfunction

  function automatic bit exp_err(input bit v0, input int c0, input bit v1, input int c1);
    bit e;
    e = 1'b0;
    if (v0 && v1 && c0 == c1 && c0 != 0) e = 1'b1;
    if (v0 && c0 != 0 && model[c0]) e = 1'b1;
    if (v1 && c1 != 0 && model[c1]) e = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = 1'b1;
  endtask

  // One functional cycle: drive, predict, then advance the model to the next edge.
  task automatic cycle(input bit dw, input int dt, input bit v0, input int c0,
                       input bit v1, input int c1, input int a0, input int a1,
                       input string name);
    exp_t e;
    @(posedge CLK);
    #1;
    dest_write = dw; dest_tag = phys_reg_tag_t'(dt);
    cb0_valid  = v0; cb0_tag  = phys_reg_tag_t'(c0);
    cb1_valid  = v1; cb1_tag  = phys_reg_tag_t'(c1);
    src0_tag   = phys_reg_tag_t'(a0);
    src1_tag   = phys_reg_tag_t'(a1);
    e.name = name;
    e.s0   = rd(a0, v0, c0, v1, c1);
    e.s1   = rd(a1, v0, c0, v1, c1);
    e.err  = exp_err(v0, c0, v1, c1);
    q.push_back(e);
    if (v0) model[c0] = 1'b1;
    if (v1) model[c1] = 1'b1;
    if (dw) model[dt] = 1'b0;
    model[0] = 1'b1;
  endtask

  // Reset pulse between edges with random write traffic; outputs must read 1,1,0.
  task automatic pulse_reset(input int a0, input int a1, input string name);
    exp_t e;
    @(posedge CLK);
    #1;
    dest_write = 1'($urandom); dest_tag = phys_reg_tag_t'($urandom);
    cb0_valid  = 1'($urandom); cb0_tag  = phys_reg_tag_t'($urandom);
    cb1_valid  = 1'($urandom); cb1_tag  = phys_reg_tag_t'($urandom);
    src0_tag   = phys_reg_tag_t'(a0);
    src1_tag   = phys_reg_tag_t'(a1);
    #1;
    nRST = 1'b0;
    e.name = name; e.s0 = 1'b1; e.s1 = 1'b1; e.err = 1'b0;
    q.push_back(e);
    model_reset();
    @(negedge CLK);
    #1;
    dest_write = 1'b0; cb0_valid = 1'b0; cb1_valid = 1'b0;
    nRST = 1'b1;
  endtask

  // Monitor: outputs are combinational, so one prediction is consumed per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({src0_ready, src1_ready, DUT_error} !== {e.s0, e.s1, e.err}) begin
          n_fail++;
          $display("FAIL %s: got s0=%b s1=%b err=%b, expected s0=%b s1=%b err=%b",
                   e.name, src0_ready, src1_ready, DUT_error, e.s0, e.s1, e.err);
        end
      end
    end
  end

  initial begin
    int  t0, t1, d;
    bit  v0, v1, dw;
    nRST = 1'b0;
    dest_write = 1'b0; dest_tag = '0;
    cb0_valid = 1'b0; cb0_tag = '0;
    cb1_valid = 1'b0; cb1_tag = '0;
    src0_tag = '0; src1_tag = '0;
    model_reset();

    pulse_reset(7, 33, "reset_a");
    pulse_reset(0, 63, "reset_b");
    cycle(0, 0, 0, 0, 0, 0, 1, 2, "idle_a");
    cycle(0, 0, 0, 0, 0, 0, 63, 0, "idle_b");

    cycle(1, 5, 0, 0, 0, 0, 5, 6, "clear5_same_cycle");
    cycle(0, 0, 0, 0, 0, 0, 5, 6, "clear5_read");
    cycle(0, 0, 1, 5, 0, 0, 5, 6, "complete5_same");
    cycle(0, 0, 0, 0, 0, 0, 5, 6, "complete5_after");

    cycle(1, 9, 0, 0, 0, 0, 9, 5, "clear9");
    cycle(1, 9, 0, 0, 1, 9, 9, 8, "clear_vs_set9");
    cycle(0, 0, 0, 0, 0, 0, 9, 8, "clear_wins9");
    cycle(1, 0, 0, 0, 0, 0, 0, 9, "write_tag0");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "tag0_ready");

    cycle(1, 12, 0, 0, 0, 0, 12, 1, "clear12");
    cycle(0, 0, 1, 12, 1, 12, 12, 1, "err_dup12");
    cycle(0, 0, 1, 20, 0, 0, 20, 12, "err_set20");
    cycle(0, 0, 1, 0, 1, 0, 0, 12, "no_err_tag0");

    cycle(1, 3, 0, 0, 0, 0, 3, 4, "clear3");
    cycle(1, 4, 0, 0, 0, 0, 3, 4, "clear4");
    cycle(0, 0, 0, 0, 0, 0, 3, 4, "read34_cleared");
    pulse_reset(3, 4, "async_reset34");
    cycle(0, 0, 0, 0, 0, 0, 3, 4, "after_reset34");

    for (int i = 0; i < 400; i++) begin
      dw = ($urandom_range(0, 2) != 0);
      d  = $urandom_range(0, 15);
      v0 = ($urandom_range(0, 2) == 0);
      v1 = ($urandom_range(0, 2) == 0);
      t0 = $urandom_range(0, 15);
      t1 = $urandom_range(0, 15);
      if (i % 150 == 149)
        pulse_reset($urandom_range(0, 15), $urandom_range(0, 15), "rand_reset");
      else
        cycle(dw, d, v0, t0, v1, t1, $urandom_range(0, 15), $urandom_range(0, 15), "random");
    end

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge CLK);
    @(negedge CLK);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
